// File: rtl/input_debounce_sync.sv
// input_debounce_sync
//   Synchronises an asynchronous, bouncy input into the clk domain. A new
//   level reaches dout only after it has held for STABLE_CYCLES en-qualified
//   ticks. dout comes straight from a flop, so it is glitch-free.
//   Optional feature macro: DEBOUNCE_EDGE_EN adds the registered rise/fall
//   pulse outputs. With the macro undefined those ports do not exist.
module input_debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic busy
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: shifts every cycle, independent of en.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Qualification FSM: next state, next count and next output level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((s != dout_q) && en) begin
                    // A single-tick filter needs no SETTLE visit; the
                    // qualifying tick itself commits the new level.
                    if (STABLE_CYCLES == 1) begin
                        dout_d = s;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CW'(1);
                    end
                end
            end
            SETTLE: begin
                if (s == dout_q) begin
                    // Bounce back to the current level: abort, and
                    // discard the partial count.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == LAST) begin
                        dout_d  = s;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and debounced output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == SETTLE);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses: registered alongside dout so they align with its change.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
